matvec8_pp_sched: RTL

- Control/scheduling block for the 8x8 matrix-vector datapath. It sequences weight loads, vector loads, multiply-accumulate and result handoff.
- Differs from the single-buffer controller: the vector store is ping-pong (2 banks), so the next vector loads while the current one computes.
- Drives a two-bank datapath variant with separate vector write/read ports. It sits between the top-level handshake pins and that datapath.

---
 rtl/matvec_sched_pkg.sv | 23 ++
 rtl/matvec_bank_tracker.sv | 47 ++++
 rtl/matvec8_pp_sched.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/matvec_sched_pkg.sv
// Shared types and default geometry for the ping-pong matrix-vector scheduler.
package matvec_sched_pkg;

  localparam int N_DEF    = 8;
  localparam int AW_W_DEF = $clog2(N_DEF * N_DEF);
  localparam int AW_X_DEF = $clog2(N_DEF);

  // Packet loader: header beat, weight body, vector body.
  typedef enum logic [1:0] {
    L_HDR = 2'd0,
    L_W   = 2'd1,
    L_X   = 2'd2
  } load_state_t;

  // Row engine: idle, clear accumulator, multiply-accumulate, present result.
  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_CLR  = 2'd1,
    C_MAC  = 2'd2,
    C_OUT  = 2'd3
  } comp_state_t;

endpackage

// File: rtl/matvec_bank_tracker.sv
// Full/empty bookkeeping for the two vector banks plus the write and read
// bank pointers. A set always targets the write bank and a clear always
// targets the read bank; both may happen in the same cycle.
module matvec_bank_tracker (
  input  logic clk,
  input  logic rst,
  input  logic i_set_full,
  input  logic i_clr_full,
  output logic o_wr_ptr,
  output logic o_rd_ptr,
  output logic o_wr_empty,
  output logic o_rd_full,
  output logic o_both_empty
);

  logic [1:0] r_full;
  logic       r_wr_ptr;
  logic       r_rd_ptr;
  logic [1:0] w_full_nxt;

  // Next full flags: clear the read bank, then mark the write bank full.
  always_comb begin
    w_full_nxt = r_full;
    if (i_clr_full) w_full_nxt[r_rd_ptr] = 1'b0;
    if (i_set_full) w_full_nxt[r_wr_ptr] = 1'b1;
  end

  // Flag and pointer registers; each pointer advances when its bank changes hands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full   <= 2'b00;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      r_full <= w_full_nxt;
      if (i_set_full) r_wr_ptr <= ~r_wr_ptr;
      if (i_clr_full) r_rd_ptr <= ~r_rd_ptr;
    end
  end

  assign o_wr_ptr     = r_wr_ptr;
  assign o_rd_ptr     = r_rd_ptr;
  assign o_wr_empty   = ~r_full[r_wr_ptr];
  assign o_rd_full    = r_full[r_rd_ptr];
  assign o_both_empty = (r_full == 2'b00);

endmodule

// File: rtl/matvec8_pp_sched.sv
// Scheduler for the two-bank 8x8 matrix-vector datapath. Loads weight and
// vector packets from the input handshake, runs one row (clear, N MACs,
// result handoff) per N+2 cycles and lets the next vector fill the idle
// bank while the current one computes.
// Optional build macro MATVEC_PERF_CNT_EN adds the stall_cycles and
// vec_done saturating performance counters.
module matvec8_pp_sched
  import matvec_sched_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int AW_W = $clog2(N * N),
  parameter int AW_X = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            input_valid,
  output logic            input_ready,
  input  logic            new_matrix,
  output logic            output_valid,
  input  logic            output_ready,
  output logic [AW_W-1:0] addr_w,
  output logic            wr_en_w,
  output logic [AW_X-1:0] addr_x_wr,
  output logic            x_wr_bank,
  output logic            wr_en_x,
  output logic [AW_X-1:0] addr_x_rd,
  output logic            x_rd_bank,
  output logic            clear_acc,
  output logic            en_acc
`ifdef MATVEC_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cycles,
  output logic [15:0]     vec_done
`endif
);

  localparam logic [AW_W-1:0] W_LAST = AW_W'(N * N - 1);
  localparam logic [AW_X-1:0] X_LAST = AW_X'(N - 1);

  load_state_t     r_ld_state;
  load_state_t     w_ld_nxt;
  comp_state_t     r_c_state;
  comp_state_t     w_c_nxt;

  logic [AW_W-1:0] r_wcnt;
  logic [AW_X-1:0] r_xcnt;
  logic [AW_X-1:0] r_row;
  logic [AW_X-1:0] r_col;
  logic            r_weights_valid;

  logic            w_in_ready;
  logic            w_wr_w;
  logic            w_wr_x;
  logic            w_set_full;
  logic            w_clr_full;
  logic            w_out_valid;
  logic            w_clr_acc;
  logic            w_en_acc;
  logic            w_c_idle;
  logic [AW_W-1:0] w_mac_addr;

  logic            w_wr_ptr;
  logic            w_rd_ptr;
  logic            w_wr_empty;
  logic            w_rd_full;
  logic            w_both_empty;

  matvec_bank_tracker u_banks (
    .clk          (clk),
    .rst          (rst),
    .i_set_full   (w_set_full),
    .i_clr_full   (w_clr_full),
    .o_wr_ptr     (w_wr_ptr),
    .o_rd_ptr     (w_rd_ptr),
    .o_wr_empty   (w_wr_empty),
    .o_rd_full    (w_rd_full),
    .o_both_empty (w_both_empty)
  );

  assign w_c_idle   = (r_c_state == C_IDLE);
  assign w_mac_addr = AW_W'(r_row) * AW_W'(N) + AW_W'(r_col);

  // Loader next state and write strobes; ready never looks at input_valid.
  always_comb begin
    w_ld_nxt   = r_ld_state;
    w_in_ready = 1'b0;
    w_wr_w     = 1'b0;
    w_wr_x     = 1'b0;
    w_set_full = 1'b0;
    case (r_ld_state)
      L_HDR: begin
        // A weight packet needs a fully drained pipeline; a vector needs
        // loaded weights and a free bank.
        if (new_matrix) w_in_ready = w_c_idle && w_both_empty;
        else            w_in_ready = r_weights_valid && w_wr_empty;
        if (input_valid && w_in_ready) begin
          if (new_matrix) begin
            w_wr_w   = 1'b1;
            w_ld_nxt = L_W;
          end else begin
            w_wr_x   = 1'b1;
            w_ld_nxt = L_X;
          end
        end
      end
      L_W: begin
        w_in_ready = 1'b1;
        if (input_valid) begin
          w_wr_w = 1'b1;
          if (r_wcnt == W_LAST) w_ld_nxt = L_HDR;
        end
      end
      L_X: begin
        w_in_ready = 1'b1;
        if (input_valid) begin
          w_wr_x = 1'b1;
          if (r_xcnt == X_LAST) begin
            w_set_full = 1'b1;
            w_ld_nxt   = L_HDR;
          end
        end
      end
      default: w_ld_nxt = L_HDR;
    endcase
  end

  // Loader state, word counters and the weights-loaded flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ld_state      <= L_HDR;
      r_wcnt          <= '0;
      r_xcnt          <= '0;
      r_weights_valid <= 1'b0;
    end else begin
      r_ld_state <= w_ld_nxt;
      if (w_wr_w) begin
        r_wcnt <= (r_wcnt == W_LAST) ? '0 : r_wcnt + AW_W'(1);
        if (r_wcnt == W_LAST) r_weights_valid <= 1'b1;
      end
      if (w_wr_x) r_xcnt <= (r_xcnt == X_LAST) ? '0 : r_xcnt + AW_X'(1);
    end
  end

  // Row engine next state and datapath strobes.
  always_comb begin
    w_c_nxt     = r_c_state;
    w_clr_acc   = 1'b0;
    w_en_acc    = 1'b0;
    w_out_valid = 1'b0;
    w_clr_full  = 1'b0;
    case (r_c_state)
      C_IDLE: if (w_rd_full) w_c_nxt = C_CLR;
      C_CLR: begin
        w_clr_acc = 1'b1;
        w_c_nxt   = C_MAC;
      end
      C_MAC: begin
        w_en_acc = 1'b1;
        if (r_col == X_LAST) w_c_nxt = C_OUT;
      end
      C_OUT: begin
        w_out_valid = 1'b1;
        if (output_ready) begin
          if (r_row == X_LAST) begin
            // Last row handed off: release the bank to the loader.
            w_clr_full = 1'b1;
            w_c_nxt    = C_IDLE;
          end else begin
            w_c_nxt = C_CLR;
          end
        end
      end
      default: w_c_nxt = C_IDLE;
    endcase
  end

  // Row engine state plus row and column counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_c_state <= C_IDLE;
      r_row     <= '0;
      r_col     <= '0;
    end else begin
      r_c_state <= w_c_nxt;
      if (w_en_acc) r_col <= (r_col == X_LAST) ? '0 : r_col + AW_X'(1);
      if (w_out_valid && output_ready) r_row <= (r_row == X_LAST) ? '0 : r_row + AW_X'(1);
    end
  end

  // Weight loads happen only while the row engine is idle, so the shared
  // weight address follows the loader then and the MAC walk otherwise.
  assign addr_w       = w_c_idle ? r_wcnt : w_mac_addr;
  assign wr_en_w      = w_wr_w;
  assign addr_x_wr    = r_xcnt;
  assign x_wr_bank    = w_wr_ptr;
  assign wr_en_x      = w_wr_x;
  assign addr_x_rd    = r_col;
  assign x_rd_bank    = w_rd_ptr;
  assign clear_acc    = w_clr_acc;
  assign en_acc       = w_en_acc;
  assign output_valid = w_out_valid;
  assign input_ready  = w_in_ready;

`ifdef MATVEC_PERF_CNT_EN
  logic [15:0] r_stall_cycles;
  logic [15:0] r_vec_done;

  // Saturating counts of back-pressured result cycles and finished vectors.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cycles <= '0;
      r_vec_done     <= '0;
    end else begin
      if (w_out_valid && !output_ready && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
      if (w_clr_full && (r_vec_done != 16'hFFFF))
        r_vec_done <= r_vec_done + 16'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign vec_done     = r_vec_done;
`endif

endmodule
